// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared state type and defaults for instr_sequencer (S_HOLD exists only with INSTR_SEQ_STEP_EN)
package instr_seq_pkg;
  localparam int INSTR_W = 16;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_TIMEOUT = 15;
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_LOAD,
    S_CALC,
    S_WAIT,
    S_ADV,
    S_FAULT
`ifdef INSTR_SEQ_STEP_EN
    , S_HOLD
`endif
  } seq_state_e;
endpackage

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: DEPTH x 16 program store, synchronous write, asynchronous read, contents survive reset
module seq_prog_mem
  import instr_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  // single write port; no reset so the program outlives a sequencer reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues stored instructions to the control unit with en_i/en_s/en_c, captures results, watchdog on done (INSTR_SEQ_STEP_EN adds single-step HOLD)
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [AW-1:0]      last_addr,
  input  logic               start,
`ifdef INSTR_SEQ_STEP_EN
  input  logic               step,
`endif
  input  logic               cu_done,
  input  logic [INSTR_W-1:0] cu_d_out,
  output logic [INSTR_W-1:0] instruction,
  output logic               en_i,
  output logic               en_s,
  output logic               en_c,
  output logic [AW-1:0]      pc,
  output logic [INSTR_W-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic               finished,
  output logic               error
);
  localparam int WW = $clog2(TIMEOUT + 1);
  seq_state_e state, state_n;
  logic [AW-1:0] end_q;
  logic [WW-1:0] wdog;
  logic [INSTR_W-1:0] mem_rdata;
  logic last;
  assign last = pc == end_q;
  seq_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(prog_we && state == S_IDLE),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc),
    .rdata(mem_rdata)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_n;
  // next state and strobes; done wins over the watchdog in the same WAIT cycle
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_FETCH : S_IDLE;
      S_FETCH: state_n = S_ISSUE;
      S_ISSUE: state_n = S_LOAD;
      S_LOAD:  state_n = S_CALC;
      S_CALC:  state_n = S_WAIT;
      S_WAIT:  state_n = cu_done ? S_ADV : wdog == WW'(TIMEOUT) ? S_FAULT : S_WAIT;
`ifdef INSTR_SEQ_STEP_EN
      S_ADV:   state_n = last ? S_IDLE : S_HOLD;
      S_HOLD:  state_n = step ? S_FETCH : S_HOLD;
`else
      S_ADV:   state_n = last ? S_IDLE : S_FETCH;
`endif
      default: state_n = S_IDLE;
    endcase
    en_i = state == S_ISSUE;
    en_s = state == S_LOAD;
    en_c = state == S_CALC;
    result_valid = state == S_ADV;
    finished = state == S_ADV && last;
    busy = state != S_IDLE;
  end
  // datapath: program bounds, fetch latch, watchdog, result capture, sticky fault
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      end_q <= '0;
      pc <= '0;
      instruction <= '0;
      wdog <= '0;
      result <= '0;
      error <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        end_q <= last_addr;
        pc <= '0;
        error <= 1'b0;
      end
      if (state == S_FETCH) instruction <= mem_rdata;
      wdog <= state == S_WAIT ? wdog + WW'(1) : '0;
      if (state == S_WAIT && cu_done) result <= cu_d_out;
      if (state == S_ADV && !last) pc <= pc + AW'(1);
      if (state == S_FAULT) error <= 1'b1;
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized programs checked cycle by cycle against a timeline model (INSTR_SEQ_STEP_EN adds the HOLD stall test)
`timescale 1ns/1ps
module tb_instr_sequencer;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int TO = 15;
`ifdef INSTR_SEQ_STEP_EN
  localparam int P = 8;
  logic step = 1'b1;
`else
  localparam int P = 7;
`endif
  logic clk = 1'b0, reset = 1'b1, prog_we = 1'b0, start = 1'b0, cu_done = 1'b0;
  logic [AW-1:0] prog_addr = '0, last_addr = '0, pc;
  logic [15:0] prog_data = '0, cu_d_out = '0, instruction, result;
  logic en_i, en_s, en_c, result_valid, busy, finished, error;
  logic [15:0] model [DEPTH];
  logic [15:0] salt = '0, last_res = '0;
  bit cu_ok = 1'b1;
  int dly = 0, total = 0, bad = 0;

  instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .last_addr(last_addr), .start(start),
`ifdef INSTR_SEQ_STEP_EN
    .step(step),
`endif
    .cu_done(cu_done), .cu_d_out(cu_d_out), .instruction(instruction), .en_i(en_i), .en_s(en_s),
    .en_c(en_c), .pc(pc), .result(result), .result_valid(result_valid), .busy(busy),
    .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  // behavioural control unit: done two cycles after en_c, result = instruction ^ salt
  always @(negedge clk) begin
    cu_done = 1'b0;
    if (dly == 1) begin
      cu_done = cu_ok;
      cu_d_out = instruction ^ salt;
    end
    if (dly != 0) dly--;
    if (en_c) dly = 2;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(int a, logic [15:0] d);
    prog_we = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    model[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // one run of n instructions from address 0; poke drives prog_we/start while busy
  task automatic run(int n, bit poke);
    int j, r;
    last_addr = AW'(n - 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prog_we = 1'b0;
    last_addr = AW'($urandom);
    for (int c = 1; c <= P * (n - 1) + 8; c++) begin
      j = (c - 1) / P;
      r = (c - 1) % P + 1;
      if (c <= P * (n - 1) + 7) begin
        chk("busy", busy, 1);
        chk("strobes", {en_i, en_s, en_c}, {r == 2, r == 3, r == 4});
        chk("result_valid", result_valid, r == 7);
        chk("finished", finished, r == 7 && j == n - 1);
        chk("pc", pc, r == 8 ? j + 1 : j);
        chk("error", error, 0);
        if (r >= 2) chk("instruction", instruction, model[j]);
        if (r == 7) begin
          last_res = model[j] ^ salt;
          chk("result", result, last_res);
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_outs", {en_i, en_s, en_c, result_valid, finished}, 0);
        chk("idle_result", result, last_res);
        chk("idle_pc", pc, n - 1);
      end
      if (poke && c == 3) begin
        prog_we = 1'b1;
        prog_addr = '0;
        prog_data = ~model[0];
        start = 1'b1;
      end else begin
        prog_we = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {instruction, pc, result, en_i, en_s, en_c, result_valid, busy, finished, error}, 0);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(i, 16'($urandom));
    wr(0, 16'h2408);
    salt = 16'h2408 ^ 16'h0055;
    run(1, 0);
    chk("first_result", result, 16'h0055);
    salt = 16'($urandom);
    run(3, 0);
    run(DEPTH, 0);
    run(2, 1);
    prog_we = 1'b1;
    prog_addr = '0;
    prog_data = 16'($urandom);
    model[0] = prog_data;
    run(1, 0);
    cu_ok = 1'b0;
    last_addr = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= TO + 9; c++) begin
      chk("wd_rv", result_valid, 0);
      chk("wd_busy", busy, c <= TO + 6);
      chk("wd_error", error, c > TO + 6);
      if (c > TO + 6) chk("wd_result", result, last_res);
      @(negedge clk);
    end
    cu_ok = 1'b1;
    salt = 16'($urandom);
    run(2, 0);
    last_addr = AW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_calc", en_c, 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_outs", {instruction, pc, result, en_i, en_s, en_c, result_valid, busy, finished, error}, 0);
    @(negedge clk);
    reset = 1'b0;
    last_res = '0;
    @(negedge clk);
    run(2, 0);
`ifdef INSTR_SEQ_STEP_EN
    step = 1'b0;
    last_addr = AW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("hs_first_rv", result_valid, 1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("hold_busy", busy, 1);
      chk("hold_strobes", {en_i, en_s, en_c, result_valid}, 0);
      chk("hold_pc", pc, 1);
      start = c == 1;
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_fetch", {en_i, busy}, 2'b01);
    @(negedge clk);
    chk("step_en_i", en_i, 1);
    chk("step_instr", instruction, model[1]);
    begin
      int k;
      k = 0;
      while (!finished && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("step_finished_seen", finished, 1);
      chk("step_result", result, model[1] ^ salt);
    end
    step = 1'b1;
    @(negedge clk);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
